floating_point_multiplier_stream: RTL and testbench
===================================================

Name: floating_point_multiplier_stream

Overview:
- Parametrised, multi-lane, fully pipelined IEEE-754-style multiplier with a valid/ready stream interface.
- Each lane computes one product per accepted beat.
- Adds backpressure, per-beat rounding mode (RNE/RTZ), correct renormalisation out of the exponent-zero boundary, and overflow/underflow/invalid flags.
- Sits in the datapath wherever the existing multiplier is used and a stalling consumer must be tolerated.

Parameters:
- EXP_WIDTH, 8, exponent bits; bias = 2^(EXP_WIDTH-1)-1
- FRAC_WIDTH, 23, stored fraction bits; FP_WIDTH = 1+EXP_WIDTH+FRAC_WIDTH
- LANES, 1, independent multipliers sharing one handshake
- PIPE_STAGES, 3, legal values 2 or 3. 3 = unpack | multiply | normalise+round; 2 merges unpack and multiply.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  block can accept a beat
- fp_a_i  in  LANES*FP_WIDTH  operand A, lane k at [k*FP_WIDTH +: FP_WIDTH]
- fp_b_i  in  LANES*FP_WIDTH  operand B, same packing
- rnd_mode_i  in  1  0 = round-nearest-even, 1 = round-toward-zero; sampled with the beat
- out_valid_o  out  1  result beat valid
- out_ready_i  in  1  consumer accepts the result
- fp_o  out  LANES*FP_WIDTH  products
- ovf_o  out  LANES  overflow flag per lane
- unf_o  out  LANES  underflow/flush flag per lane
- nv_o  out  LANES  invalid-operation flag per lane

Behaviour:
- Reset: asynchronous on rst_ni low. All stage valid bits = 0, so out_valid_o = 0 and in_ready_o = 1 after reset. Data registers are not reset.
- Reset asserted mid-operation discards all in-flight beats. No output beat appears for them after release.
- Transfer occurs on valid && ready at a clock edge.
- Stage k register loads when it is empty or stage k+1 can load; the last stage loads when it is empty or out_ready_i = 1.
- in_ready_o = !v[0] || (stage 0 can advance). This is combinational from out_ready_i through the stage valids; no register from out_ready_i.
- Throughput is 1 beat/cycle with out_ready_i held high.
- Latency is exactly PIPE_STAGES cycles from acceptance to out_valid_o when unstalled.
- While out_valid_o && !out_ready_i: fp_o, the flags and out_valid_o are held stable. No beat is dropped or duplicated. Order is preserved.
- Simultaneous accept at input and emit at output on a full pipe is legal and sustains throughput.
- Operand classes, per lane:
  - exp = 0 is treated as zero; subnormal fraction is ignored.
  - exp = EXP_MAX with frac = 0 is infinity.
  - exp = EXP_MAX with frac ≠ 0 is NaN.
- Special cases, in priority order:
  1. Any NaN operand, or inf × zero: canonical NaN (sign 0, exp EXP_MAX, frac MSB 1, rest 0); nv = 1.
  2. inf × nonzero: infinity with sign = sa^sb.
  3. zero × finite: signed zero (sa^sb); no flags.
- Normal path:
  - Compute the full (FRAC_WIDTH+1)^2 mantissa product.
  - Form the unbiased exponent in EXP_WIDTH+2 signed bits.
  - If product ≥ 2, shift right 1 and exponent +1.
  - Round using guard and sticky (OR of all discarded bits).
  - RNE: round up if guard && (sticky || lsb).
  - RTZ: never round up.
  - If rounding carries to 2.0, renormalise again (exponent +1).
  - Over/underflow is decided only after both normalisations. A sum that starts at biased exponent 0 but renormalises to ≥ 1 is a normal result.
- Overflow (final biased exp ≥ EXP_MAX): ovf = 1. RNE gives signed infinity; RTZ gives signed max finite (exp EXP_MAX-1, frac all ones).
- Underflow (final biased exp ≤ 0): result is signed zero; unf = 1.
- Flags are valid only with out_valid_o and are mutually exclusive per lane.
- rnd_mode_i travels with its beat. Changing it between beats affects only later beats.

Test Plan (EXP_WIDTH=8, FRAC_WIDTH=23, LANES=2, PIPE_STAGES=3):
1. Basic, with per-cycle streaming. Lane0 0x3FC00000×0x40000000, lane1 0xC0400000×0x3F000000, out_ready_i=1.
   -> 0x40400000 and 0xBFC00000, out_valid_o exactly 3 cycles after accept, flags 0. Back-to-back beats are accepted every cycle.
2. Rounding. 0x3F800001×0x3FC00000.
   -> RNE 0x3FC00002 (odd tie rounds up); RTZ 0x3FC00001. Two consecutive beats with opposite rnd_mode_i each round per their own mode.
3. Range:
   - 0x7F000000×0x40000000 -> RNE 0x7F800000 ovf=1; RTZ 0x7F7FFFFF ovf=1.
   - 0x80800000×0x3F000000 -> 0x80000000 unf=1.
   - 0x00C00000×0x3F400000 -> 0x00900000, no flags (boundary renormalisation).
4. Specials:
   - 0x7F800000×0x00000000 -> 0x7FC00000 nv=1.
   - 0xFF800000×0x40000000 -> 0xFF800000, no flags.
   - 0x7FA00000×0x3F800000 -> 0x7FC00000 nv=1.
   - 0x00400000×0x40000000 -> 0x00000000, no flags.
5. Backpressure. Stream 10 beats with out_ready_i random at 50%.
   -> All 10 results emerge in order, match the reference model, and are held stable during stalls. in_ready_o drops only when all 3 stages are full and out_ready_i=0.
6. Reset. Assert rst_ni low for 1 cycle with 3 beats in flight.
   -> out_valid_o=0 immediately (asynchronous), in_ready_o=1 after release, no stale beats emitted. The next accepted beat returns in 3 cycles.

Source files
------------

// File: rtl/floating_point_multiplier_stream.sv
// rtl/floating_point_multiplier_stream.sv - multi-lane pipelined FP multiplier with valid/ready stream
// Stages: [unpack] | multiply | normalise+round; every lane shares one handshake.
module floating_point_multiplier_stream #(
   parameter int EXP_WIDTH   = 8,
   parameter int FRAC_WIDTH  = 23,
   parameter int LANES       = 1,
   parameter int PIPE_STAGES = 3,
   localparam int FP_WIDTH   = 1 + EXP_WIDTH + FRAC_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [LANES*FP_WIDTH-1:0] fp_a_i,
   input  logic [LANES*FP_WIDTH-1:0] fp_b_i,
   input  logic                      rnd_mode_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [LANES*FP_WIDTH-1:0] fp_o,
   output logic [LANES-1:0]          ovf_o,
   output logic [LANES-1:0]          unf_o,
   output logic [LANES-1:0]          nv_o
);
   localparam int M       = FRAC_WIDTH + 1;
   localparam int P       = 2 * M;
   localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
   localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

   typedef logic signed [EXP_WIDTH+1:0] sexp_t;
   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_e;

   logic [PIPE_STAGES-1:0] v;
   logic [PIPE_STAGES-1:0] load;
   logic                   acc;

   // A stage may load if it or any stage downstream of it has room.
   always_comb begin
      acc  = out_ready_i;
      load = '0;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         acc     = acc | ~v[k];
         load[k] = acc;
      end
   end

   assign in_ready_o  = load[0];
   assign out_valid_o = v[PIPE_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v <= '0;
      end else begin
         if (load[0]) v[0] <= in_valid_i;
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (load[k]) v[k] <= v[k-1];
         end
      end
   end

   logic rnd_u, rnd_m;
   if (PIPE_STAGES == 3) begin : g_rnd3
      logic rnd_q;
      always_ff @(posedge clk_i) if (load[0]) rnd_q <= rnd_mode_i;
      assign rnd_u = rnd_q;
   end else begin : g_rnd2
      assign rnd_u = rnd_mode_i;
   end
   always_ff @(posedge clk_i) if (load[PIPE_STAGES-2]) rnd_m <= rnd_u;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [FP_WIDTH-1:0]  a, b;
      logic [EXP_WIDTH-1:0] ea, eb;
      logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      spec_e                sp_c, sp_u, sp_m;
      sexp_t                es_c, es_u, es_m;
      logic                 sg_u, sg_m;
      logic [M-1:0]         ma_u, mb_u;
      logic [P-1:0]         prod_m;

      assign a      = fp_a_i[l*FP_WIDTH +: FP_WIDTH];
      assign b      = fp_b_i[l*FP_WIDTH +: FP_WIDTH];
      assign ea     = a[FP_WIDTH-2 -: EXP_WIDTH];
      assign eb     = b[FP_WIDTH-2 -: EXP_WIDTH];
      assign a_zero = (ea == '0);
      assign b_zero = (eb == '0);
      assign a_inf  = (&ea) && (a[FRAC_WIDTH-1:0] == '0);
      assign b_inf  = (&eb) && (b[FRAC_WIDTH-1:0] == '0);
      assign a_nan  = (&ea) && (a[FRAC_WIDTH-1:0] != '0);
      assign b_nan  = (&eb) && (b[FRAC_WIDTH-1:0] != '0);
      assign es_c   = sexp_t'(ea) + sexp_t'(eb) - sexp_t'(BIAS);

      always_comb begin
         if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) sp_c = SP_NAN;
         else if (a_inf || b_inf)                                      sp_c = SP_INF;
         else if (a_zero || b_zero)                                    sp_c = SP_ZERO;
         else                                                          sp_c = SP_NONE;
      end

      if (PIPE_STAGES == 3) begin : g_unpack_q
         always_ff @(posedge clk_i) begin
            if (load[0]) begin
               sp_u <= sp_c;
               sg_u <= a[FP_WIDTH-1] ^ b[FP_WIDTH-1];
               es_u <= es_c;
               ma_u <= {1'b1, a[FRAC_WIDTH-1:0]};
               mb_u <= {1'b1, b[FRAC_WIDTH-1:0]};
            end
         end
      end else begin : g_unpack_c
         assign sp_u = sp_c;
         assign sg_u = a[FP_WIDTH-1] ^ b[FP_WIDTH-1];
         assign es_u = es_c;
         assign ma_u = {1'b1, a[FRAC_WIDTH-1:0]};
         assign mb_u = {1'b1, b[FRAC_WIDTH-1:0]};
      end

      always_ff @(posedge clk_i) begin
         if (load[PIPE_STAGES-2]) begin
            sp_m   <= sp_u;
            sg_m   <= sg_u;
            es_m   <= es_u;
            prod_m <= {{M{1'b0}}, ma_u} * {{M{1'b0}}, mb_u};
         end
      end

      logic [M-1:0]          mant_n;
      logic [M:0]            mant_r;
      logic                  grd, stk, up;
      sexp_t                 e_n, e_f;
      logic [FRAC_WIDTH-1:0] frac_f;
      logic [FP_WIDTH-1:0]   res_c, res_q;
      logic                  ovf_c, unf_c, nv_c, ovf_q, unf_q, nv_q;

      // Range is judged only on e_f, after both the product and the rounding renormalisation.
      always_comb begin
         if (prod_m[P-1]) begin
            mant_n = prod_m[P-1 -: M];
            grd    = prod_m[M-1];
            stk    = |prod_m[M-2:0];
            e_n    = es_m + sexp_t'(1);
         end else begin
            mant_n = prod_m[P-2 -: M];
            grd    = prod_m[M-2];
            stk    = |prod_m[M-3:0];
            e_n    = es_m;
         end
         up     = !rnd_m && grd && (stk || mant_n[0]);
         mant_r = {1'b0, mant_n} + {{M{1'b0}}, up};
         e_f    = mant_r[M] ? e_n + sexp_t'(1) : e_n;
         frac_f = mant_r[M] ? '0 : mant_r[FRAC_WIDTH-1:0];
         res_c  = {sg_m, e_f[EXP_WIDTH-1:0], frac_f};
         ovf_c  = 1'b0;
         unf_c  = 1'b0;
         nv_c   = 1'b0;
         case (sp_m)
            SP_NAN: begin
               res_c = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
               nv_c  = 1'b1;
            end
            SP_INF:  res_c = {sg_m, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            SP_ZERO: res_c = {sg_m, {(FP_WIDTH-1){1'b0}}};
            default: begin
               if (e_f >= sexp_t'(EXP_MAX)) begin
                  ovf_c = 1'b1;
                  res_c = rnd_m ? {sg_m, {(EXP_WIDTH-1){1'b1}}, 1'b0, {FRAC_WIDTH{1'b1}}}
                                : {sg_m, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
               end else if (e_f <= sexp_t'(0)) begin
                  unf_c = 1'b1;
                  res_c = {sg_m, {(FP_WIDTH-1){1'b0}}};
               end
            end
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (load[PIPE_STAGES-1]) begin
            res_q <= res_c;
            ovf_q <= ovf_c;
            unf_q <= unf_c;
            nv_q  <= nv_c;
         end
      end

      assign fp_o[l*FP_WIDTH +: FP_WIDTH] = res_q;
      assign ovf_o[l] = ovf_q;
      assign unf_o[l] = unf_q;
      assign nv_o[l]  = nv_q;
   end
endmodule

// File: tb/tb_floating_point_multiplier_stream.sv
// tb/tb_floating_point_multiplier_stream.sv - scoreboard bench for the streaming FP multiplier
// Two lanes, three stages; directed vectors plus randomized beats under random backpressure.
module tb_floating_point_multiplier_stream;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [63:0] fp_a_i, fp_b_i;
   logic        rnd_mode_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] fp_o;
   logic [1:0]  ovf_o, unf_o, nv_o;

   floating_point_multiplier_stream #(
      .EXP_WIDTH(8), .FRAC_WIDTH(23), .LANES(2), .PIPE_STAGES(3)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .fp_a_i(fp_a_i), .fp_b_i(fp_b_i), .rnd_mode_i(rnd_mode_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .fp_o(fp_o), .ovf_o(ovf_o), .unf_o(unf_o), .nv_o(nv_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [34:0] e0;
      logic [34:0] e1;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;

   exp_t        sbq[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          ready_mode = 0;
   bit          held = 0;
   logic [69:0] h_val;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Result flags packed as {nv, unf, ovf, value}; rounding decided from the exact remainder.
   function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic rz);
      int     ea, eb, e, sh;
      bit     az, bz, ai, bi, an, bn;
      logic   s;
      longint p, q, rem, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 255) && (a[22:0] == '0);
      bi = (eb == 255) && (b[22:0] == '0);
      an = (ea == 255) && (a[22:0] != '0);
      bn = (eb == 255) && (b[22:0] != '0);
      s  = a[31] ^ b[31];
      if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 32'h7FC00000};
      if (ai || bi) return {3'b000, s, 8'hFF, 23'h0};
      if (az || bz) return {3'b000, s, 31'h0};
      p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e  = ea + eb - 127;
      sh = 23;
      if (p >= (longint'(1) << 47)) begin
         sh = 24;
         e  = e + 1;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (!rz && (rem > half || (rem == half && q[0]))) q = q + 1;
      if (q == (longint'(1) << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return rz ? {3'b001, s, 8'hFE, 23'h7FFFFF} : {3'b001, s, 8'hFF, 23'h0};
      if (e <= 0) return {3'b010, s, 31'h0};
      return {3'b000, s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rop();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 7))
         0:       x[30:23] = 8'hFF;
         1:       x[30:23] = 8'h00;
         2, 3, 4: x[30:23] = 8'($urandom_range(110, 144));
         default: ;
      endcase
      return x;
   endfunction

   task automatic send(input logic [31:0] a0, input logic [31:0] b0, input logic [34:0] e0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [34:0] e1,
                       input logic rz, input bit lat);
      int   tries;
      exp_t x;
      tries = 0;
      @(negedge clk_i);
      fp_a_i     = {a1, a0};
      fp_b_i     = {b1, b0};
      rnd_mode_i = rz;
      in_valid_i = 1'b1;
      forever begin
         #1;
         chk("in_ready", 72'(in_ready_o), 72'(!(sbq.size() == 3 && !out_ready_i)));
         if (in_ready_o) begin
            x.e0 = e0; x.e1 = e1; x.acc_cyc = cyc; x.chk_lat = lat;
            sbq.push_back(x);
            break;
         end
         tries++;
         if (tries > 300) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout got=stalled exp=accepted");
            in_valid_i = 1'b0;
            return;
         end
         @(negedge clk_i);
      end
      @(posedge clk_i);
   endtask

   task automatic idle();
      @(negedge clk_i);
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      n_chk++;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain got=%0d_pending exp=0", sbq.size());
      end
      repeat (2) @(negedge clk_i);
   endtask

   // Monitor: drives out_ready_i, checks held outputs during stalls, pops on each transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         case (ready_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'b0;
         endcase
         #2;
         if (rst_ni === 1'b1) begin
            if (held)
               chk("hold", 72'({out_valid_o, fp_o, nv_o, unf_o, ovf_o}), 72'({1'b1, h_val}));
            held = 0;
            if (out_valid_o) begin
               if (!out_ready_i) begin
                  held  = 1;
                  h_val = {fp_o, nv_o, unf_o, ovf_o};
               end else if (sbq.size() == 0) begin
                  n_chk++; n_err++;
                  $display("FAIL unexpected_beat got=%h exp=none", fp_o);
               end else begin
                  e = sbq.pop_front();
                  chk("lane0", 72'({nv_o[0], unf_o[0], ovf_o[0], fp_o[31:0]}), 72'(e.e0));
                  chk("lane1", 72'({nv_o[1], unf_o[1], ovf_o[1], fp_o[63:32]}), 72'(e.e1));
                  if (e.chk_lat) chk("latency", 72'(cyc - e.acc_cyc), 72'(3));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      fp_a_i = '0; fp_b_i = '0; in_valid_i = 1'b0; rnd_mode_i = 1'b0;
      out_ready_i = 1'b1; rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_out_valid", 72'(out_valid_o), 72'(0));
      chk("rst_in_ready", 72'(in_ready_o), 72'(1));
      rst_ni = 1'b1;

      // Directed vectors streamed back-to-back, consumer always ready.
      send(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000},
           32'hC0400000, 32'h3F000000, {3'b000, 32'hBFC00000}, 1'b0, 1);
      send(32'h3F800001, 32'h3FC00000, {3'b000, 32'h3FC00002},
           32'h3F800001, 32'h3FC00000, {3'b000, 32'h3FC00002}, 1'b0, 1);
      send(32'h3F800001, 32'h3FC00000, {3'b000, 32'h3FC00001},
           32'h3F800001, 32'h3FC00000, {3'b000, 32'h3FC00001}, 1'b1, 1);
      send(32'h7F000000, 32'h40000000, {3'b001, 32'h7F800000},
           32'h80800000, 32'h3F000000, {3'b010, 32'h80000000}, 1'b0, 1);
      send(32'h7F000000, 32'h40000000, {3'b001, 32'h7F7FFFFF},
           32'h00C00000, 32'h3F400000, {3'b000, 32'h00900000}, 1'b1, 1);
      send(32'h7F800000, 32'h00000000, {3'b100, 32'h7FC00000},
           32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000}, 1'b0, 1);
      send(32'h7FA00000, 32'h3F800000, {3'b100, 32'h7FC00000},
           32'h00400000, 32'h40000000, {3'b000, 32'h00000000}, 1'b1, 1);
      idle();
      drain();

      // Random beats with random gaps under 50% backpressure.
      ready_mode = 1;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a0, b0, a1, b1;
         logic        rz;
         a0 = rop(); b0 = rop(); a1 = rop(); b1 = rop();
         rz = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) idle();
         send(a0, b0, ref_mul(a0, b0, rz), a1, b1, ref_mul(a1, b1, rz), rz, 0);
      end
      idle();
      drain();

      // Fill the pipe against a stalled consumer, then reset it away.
      ready_mode = 2;
      for (int i = 0; i < 3; i++)
         send(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000},
              32'hC0400000, 32'h3F000000, {3'b000, 32'hBFC00000}, 1'b0, 0);
      idle();
      #1;
      chk("full_in_ready", 72'(in_ready_o), 72'(0));
      #2;
      rst_ni = 1'b0;
      held   = 0;
      #1;
      chk("async_rst_valid", 72'(out_valid_o), 72'(0));
      sbq.delete();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("post_rst_in_ready", 72'(in_ready_o), 72'(1));
      ready_mode = 0;
      repeat (6) @(negedge clk_i);
      send(32'h3F800001, 32'h3FC00000, {3'b000, 32'h3FC00001},
           32'h7F000000, 32'h40000000, {3'b001, 32'h7F7FFFFF}, 1'b1, 1);
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
